// File: rtl/npc_pkg.sv
// npc_pkg: shared stage payload types and limits for the npc core pipeline.
// Provides the payload structs carried between stages (instances set
// WIDTH = $bits(<struct>)) and the maximum stage buffer depth.
package npc_pkg;

   localparam int MAX_STAGE_DEPTH = 16;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [5:0]  op;
   } d2x_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] alu_res;
      logic [31:0] st_data;
      logic [4:0]  rd;
      logic        mem_rd;
      logic        mem_wr;
      logic        wb_en;
   } x2m_t;

   typedef struct packed {
      logic [31:0] wb_data;
      logic [4:0]  rd;
      logic        wb_en;
   } m2w_t;

endpackage

// File: rtl/stage_pipe_mem.sv
// stage_pipe_mem: DEPTH x WIDTH register array for the stage buffer.
// Ports: clk; write port wen/waddr/wdata (registered); asynchronous read
// port raddr -> rdata. Contents are deliberately not reset.
module stage_pipe_mem #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int AW    = 1
) (
   input  logic             clk,
   input  logic             wen,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wen) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/stage_pipe_buf.sv
// stage_pipe_buf: valid/ready FIFO stage buffer with flush, optional pass-through and stall counter.
// Ports: clk, rst (sync, active-low); upstream s_valid/s_ready/s_data;
// downstream m_valid/m_ready/m_data; flush empties the buffer and drops the
// incoming payload; count is occupancy; stall_cnt counts m_valid & ~m_ready
// cycles, saturating, cleared only by reset.
module stage_pipe_buf
   import npc_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int DEPTH        = 2,
   parameter int PASS_THROUGH = 0,
   parameter int CNT_W        = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [WIDTH-1:0]           s_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [WIDTH-1:0]           m_data,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [CNT_W-1:0]           stall_cnt
);

   localparam int CW    = $clog2(DEPTH+1);
   localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [WIDTH-1:0] rd_data;
   logic             bypass, push, pop, wen, rd_adv;

   // Pass-through only applies while nothing is stored, so order is preserved.
   assign bypass  = (PASS_THROUGH != 0) && (count_q == '0);
   assign s_ready = count_q != CW'(DEPTH);
   assign m_valid = bypass ? s_valid & ~flush : count_q != '0;
   assign m_data  = bypass ? s_data : rd_data;
   assign push    = s_valid & s_ready & ~flush;
   assign pop     = m_valid & m_ready & ~flush;
   // A bypassed payload taken downstream in the same cycle is never stored.
   assign wen     = push & ~(bypass & pop);
   assign rd_adv  = pop & ~bypass;
   assign count     = count_q;
   assign stall_cnt = stall_q;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      stall_d  = (m_valid & ~m_ready & (stall_q != '1)) ? stall_q + 1'b1 : stall_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wen)    wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
         if (rd_adv) rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
         count_d = count_q + CW'(wen) - CW'(rd_adv);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         stall_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         stall_q  <= stall_d;
      end
   end

   stage_pipe_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(PTR_W)) u_mem (
      .clk   (clk),
      .wen   (wen),
      .waddr (wr_ptr_q),
      .wdata (s_data),
      .raddr (rd_ptr_q),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_stage_pipe_buf.sv
// tb_stage_pipe_buf: directed bench for stage_pipe_buf across depth/pass-through configurations.
module tb_stage_pipe_buf;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic       v2 = 0, r2 = 0, f2 = 0, sr2, mv2;
   logic [7:0] d2 = 0, md2;
   logic [1:0] c2;
   logic [15:0] st2;

   logic       v4 = 0, r4 = 0, f4 = 0, sr4, mv4;
   logic [7:0] d4 = 0, md4;
   logic [2:0] c4;
   logic [15:0] st4;

   logic       v3 = 0, r3 = 0, f3 = 0, sr3, mv3;
   logic [7:0] d3 = 0, md3;
   logic [1:0] c3;
   logic [15:0] st3;

   logic       vp = 0, rp = 0, fp = 0, srp, mvp;
   logic [7:0] dp = 0, mdp;
   logic [1:0] cp;
   logic [3:0] stp;

   stage_pipe_buf #(.WIDTH(8), .DEPTH(2), .PASS_THROUGH(0), .CNT_W(16)) u2 (
      .clk(clk), .rst(rst), .s_valid(v2), .s_ready(sr2), .s_data(d2), .m_valid(mv2),
      .m_ready(r2), .m_data(md2), .flush(f2), .count(c2), .stall_cnt(st2));
   stage_pipe_buf #(.WIDTH(8), .DEPTH(4), .PASS_THROUGH(0), .CNT_W(16)) u4 (
      .clk(clk), .rst(rst), .s_valid(v4), .s_ready(sr4), .s_data(d4), .m_valid(mv4),
      .m_ready(r4), .m_data(md4), .flush(f4), .count(c4), .stall_cnt(st4));
   stage_pipe_buf #(.WIDTH(8), .DEPTH(3), .PASS_THROUGH(0), .CNT_W(16)) u3 (
      .clk(clk), .rst(rst), .s_valid(v3), .s_ready(sr3), .s_data(d3), .m_valid(mv3),
      .m_ready(r3), .m_data(md3), .flush(f3), .count(c3), .stall_cnt(st3));
   stage_pipe_buf #(.WIDTH(8), .DEPTH(2), .PASS_THROUGH(1), .CNT_W(4)) up (
      .clk(clk), .rst(rst), .s_valid(vp), .s_ready(srp), .s_data(dp), .m_valid(mvp),
      .m_ready(rp), .m_data(mdp), .flush(fp), .count(cp), .stall_cnt(stp));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic reset_all;
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   initial begin
      logic [15:0] pat;
      int sent, rcvd, cm;
      logic psh, pp;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rst_s_ready", sr2, 1);
      chk("rst_m_valid", mv2, 0);
      chk("rst_count", c2, 0);
      chk("rst_stall", st2, 0);
      tick();

      // 1: depth 2, streaming with m_ready held high
      v2 = 1; r2 = 1; d2 = 8'h0A;
      @(negedge clk); chk("t1_mv0", mv2, 0); chk("t1_sr0", sr2, 1); tick();
      d2 = 8'h0B;
      @(negedge clk); chk("t1_d0", md2, 8'h0A); chk("t1_c0", c2, 1); chk("t1_sr1", sr2, 1); tick();
      d2 = 8'h0C;
      @(negedge clk); chk("t1_d1", md2, 8'h0B); chk("t1_c1", c2, 1); chk("t1_sr2", sr2, 1); tick();
      v2 = 0;
      @(negedge clk); chk("t1_d2", md2, 8'h0C); chk("t1_mv2", mv2, 1); tick();
      @(negedge clk); chk("t1_empty", mv2, 0); chk("t1_c3", c2, 0);

      // 2: depth 4 fills under back-pressure then drains in order
      tick(); reset_all();
      v4 = 1; r4 = 0;
      for (int i = 0; i < 4; i++) begin
         d4 = 8'(8'h10 + i);
         @(negedge clk); chk("t2_fill_count", c4, i); chk("t2_fill_sr", sr4, 1);
         tick();
      end
      d4 = 8'h14;
      @(negedge clk); chk("t2_full_count", c4, 4); chk("t2_full_sr", sr4, 0);
      chk("t2_stall3", st4, 3); chk("t2_head", md4, 8'h10);
      tick();
      r4 = 1;
      @(negedge clk); chk("t2_dr0", md4, 8'h10); chk("t2_sr_held", sr4, 0); chk("t2_stall4", st4, 4); tick();
      @(negedge clk); chk("t2_dr1", md4, 8'h11); chk("t2_sr_back", sr4, 1); chk("t2_c_after_pop", c4, 3); tick();
      v4 = 0;
      @(negedge clk); chk("t2_dr2", md4, 8'h12); chk("t2_c_pushpop", c4, 3); tick();
      @(negedge clk); chk("t2_dr3", md4, 8'h13); tick();
      @(negedge clk); chk("t2_dr4", md4, 8'h14); chk("t2_c_last", c4, 1); tick();
      @(negedge clk); chk("t2_drained", mv4, 0); chk("t2_stall_end", st4, 4);

      // 3: depth 3 wrap with irregular m_ready
      tick(); reset_all();
      pat = 16'b0110_1011_0100_1000;
      sent = 0; rcvd = 0; cm = 0;
      for (int cyc = 0; cyc < 100 && rcvd < 10; cyc++) begin
         r3 = pat[cyc % 16];
         v3 = sent < 10;
         d3 = 8'(sent);
         @(negedge clk);
         chk("t3_count", c3, cm);
         chk("t3_sr", sr3, cm != 3);
         psh = v3 && sr3;
         pp  = mv3 && r3;
         if (pp) begin
            chk("t3_data", md3, rcvd);
            rcvd++;
         end
         if (psh) sent++;
         cm = cm + int'(psh) - int'(pp);
         tick();
      end
      v3 = 0; r3 = 0;
      chk("t3_received", rcvd, 10);

      // 4: flush with three entries and an incoming payload
      reset_all();
      v4 = 1; r4 = 0;
      for (int i = 0; i < 3; i++) begin
         d4 = 8'(8'h21 + i);
         tick();
      end
      f4 = 1; d4 = 8'h99;
      @(negedge clk); chk("t4_pre_count", c4, 3); chk("t4_pre_stall", st4, 2); tick();
      f4 = 0; v4 = 0;
      @(negedge clk); chk("t4_count", c4, 0); chk("t4_mv", mv4, 0);
      chk("t4_sr", sr4, 1); chk("t4_stall_kept", st4, 3);
      tick();
      v4 = 1; d4 = 8'h31; tick(); v4 = 0;
      @(negedge clk); chk("t4_next_data", md4, 8'h31); chk("t4_next_count", c4, 1);

      // 5: pass-through, then stall saturation, then reset mid-stream
      tick(); reset_all();
      vp = 1; dp = 8'h55; rp = 1;
      @(negedge clk); chk("t5_mv", mvp, 1); chk("t5_data", mdp, 8'h55); chk("t5_count", cp, 0); tick();
      rp = 0; dp = 8'h66;
      @(negedge clk); chk("t5_mv2", mvp, 1); chk("t5_data2", mdp, 8'h66); chk("t5_c_bypass", cp, 0); tick();
      vp = 0;
      @(negedge clk); chk("t5_c_stored", cp, 1); chk("t5_head", mdp, 8'h66); chk("t5_stall1", stp, 1);
      repeat (20) tick();
      @(negedge clk); chk("t6_sat", stp, 15);
      vp = 1; dp = 8'h77; tick();
      @(negedge clk); chk("t6_c2", cp, 2); chk("t6_sr0", srp, 0); chk("t6_head", mdp, 8'h66);
      rst = 0; vp = 1; rp = 1; tick();
      rst = 1; vp = 0;
      @(negedge clk); chk("t6_mv", mvp, 0); chk("t6_count", cp, 0);
      chk("t6_stall", stp, 0); chk("t6_sr", srp, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
